// File: rtl/la_pattern_player_if.sv
//------------------------------------------------------------------------------
// la_pattern_player_if : host load/control and playback bus of the pattern player
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface la_pattern_player_if #(
  parameter int NUM_CHANNELS = 7,
  parameter int PTR_W        = 4
) ();
  logic                    ena;
  logic                    load_valid;
  logic [NUM_CHANNELS-1:0] load_data;
  logic                    load_ready;
  logic                    clear;
  logic                    start;
  logic                    stop;
  logic                    loop;
  logic [3:0]              div;
  logic [NUM_CHANNELS-1:0] play_out;
  logic                    play_valid;
  logic                    busy;
  logic                    done;
  logic [PTR_W-1:0]        count;

  modport master (
    output ena, load_valid, load_data, clear, start, stop, loop, div,
    input  load_ready, play_out, play_valid, busy, done, count
  );

  modport slave (
    input  ena, load_valid, load_data, clear, start, stop, loop, div,
    output load_ready, play_out, play_valid, busy, done, count
  );
endinterface

`default_nettype wire

// File: rtl/la_pattern_player.sv
//------------------------------------------------------------------------------
// la_pattern_player : stores up to DEPTH sample words and replays them at div+1 cycles/word
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module la_pattern_player #(
  parameter int NUM_CHANNELS = 7,
  parameter int DEPTH        = 10,
  parameter int PTR_W        = 4
) (
  input  wire                    clk,
  input  wire                    rst_n,
  la_pattern_player_if.slave     bus
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_PLAY = 1'b1
  } state_t;

  state_t                  state_q, state_d;
  logic [PTR_W-1:0]        count_q, count_d;
  logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
  logic [3:0]              period_q, period_d;
  logic [NUM_CHANNELS-1:0] play_out_q, play_out_d;
  logic                    play_valid_q, play_valid_d;
  logic                    done_q, done_d;
  logic [NUM_CHANNELS-1:0] mem_q [DEPTH];

  logic                    w_load_ready;
  logic                    w_load_accept;
  logic                    w_mem_we;

  assign w_load_ready  = (state_q == ST_IDLE) && (count_q < PTR_W'(DEPTH));
  assign w_load_accept = bus.load_valid && w_load_ready;

  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    rd_ptr_d     = rd_ptr_q;
    period_d     = period_q;
    play_out_d   = play_out_q;
    play_valid_d = play_valid_q;
    done_d       = done_q;
    w_mem_we     = 1'b0;

    if (bus.ena) begin
      done_d = 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (bus.clear) begin
            count_d = '0;
          end else begin
            if (w_load_accept) begin
              w_mem_we = 1'b1;
              count_d  = count_q + PTR_W'(1);
            end
            // A word loaded into an empty store this cycle is word 0 of the launch.
            if (bus.start && !bus.stop && ((count_q != '0) || w_load_accept)) begin
              state_d      = ST_PLAY;
              rd_ptr_d     = '0;
              period_d     = bus.div;
              play_valid_d = 1'b1;
              play_out_d   = (count_q == '0) ? bus.load_data : mem_q[0];
            end
          end
        end
        ST_PLAY: begin
          if (bus.stop) begin
            state_d      = ST_IDLE;
            rd_ptr_d     = '0;
            period_d     = '0;
            play_out_d   = '0;
            play_valid_d = 1'b0;
          end else if (period_q != 4'd0) begin
            period_d = period_q - 4'd1;
          end else if (rd_ptr_q == (count_q - PTR_W'(1))) begin
            if (bus.loop) begin
              rd_ptr_d   = '0;
              period_d   = bus.div;
              play_out_d = mem_q[0];
            end else begin
              state_d      = ST_IDLE;
              rd_ptr_d     = '0;
              play_out_d   = '0;
              play_valid_d = 1'b0;
              done_d       = 1'b1;
            end
          end else begin
            rd_ptr_d   = rd_ptr_q + PTR_W'(1);
            period_d   = bus.div;
            play_out_d = mem_q[rd_ptr_q + PTR_W'(1)];
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      count_q      <= '0;
      rd_ptr_q     <= '0;
      period_q     <= '0;
      play_out_q   <= '0;
      play_valid_q <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      rd_ptr_q     <= rd_ptr_d;
      period_q     <= period_d;
      play_out_q   <= play_out_d;
      play_valid_q <= play_valid_d;
      done_q       <= done_d;
    end
  end

  // Pattern memory is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (rst_n && w_mem_we) begin
      mem_q[count_q] <= bus.load_data;
    end
  end

  assign bus.load_ready = w_load_ready;
  assign bus.play_out   = play_out_q;
  assign bus.play_valid = play_valid_q;
  assign bus.busy       = (state_q == ST_PLAY);
  assign bus.done       = done_q;
  assign bus.count      = count_q;

endmodule

`default_nettype wire
